// File: rtl/trig_prm_pkg.sv
// -----------------------------------------------------------------------------
// trig_prm_pkg
// Shared definitions for the trigger-parameter scheduler:
//   - FSM state encoding
//   - default frame-sync timeout and post-write settle length
//   - bit positions of the fields inside a 32-bit parameter word
//   - prm_word(): builds a parameter word from its fields
// No ports (package).
// -----------------------------------------------------------------------------
package trig_prm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_SYNC = 2'd1,
        ST_WRITE     = 2'd2,
        ST_SETTLE    = 2'd3
    } state_e;

    localparam logic [23:0] TIMEOUT_DEFAULT = 24'd2_100_000;
    localparam logic [3:0]  SETTLE_DEFAULT  = 4'd4;

    // Parameter word layout
    localparam int unsigned PRM_ACTIVE_BIT = 25;
    localparam int unsigned PRM_MODE_BIT   = 24;
    localparam int unsigned PRM_COUNT_MSB  = 23;
    localparam int unsigned PRM_COUNT_LSB  = 0;

    // Assemble a parameter word; unused upper bits are zero.
    function automatic logic [31:0] prm_word(input logic        active,
                                             input logic        mode,
                                             input logic [23:0] count);
        logic [31:0] w;
        w                               = 32'd0;
        w[PRM_ACTIVE_BIT]               = active;
        w[PRM_MODE_BIT]                 = mode;
        w[PRM_COUNT_MSB:PRM_COUNT_LSB]  = count;
        return w;
    endfunction

endpackage

// File: rtl/trig_prm_scheduler_if.sv
// -----------------------------------------------------------------------------
// trig_prm_scheduler_if
// Request handshake between the two parameter producers and the scheduler.
//   req_valid [1:0]  per-requester write request (bit0 host, bit1 sequencer)
//   req_data  [63:0] {req1 word, req0 word}
//   req_ready [1:0]  one-hot, one-cycle accept pulse to the granted requester
// Modports: master (requesters), slave (scheduler).
// -----------------------------------------------------------------------------
interface trig_prm_scheduler_if;

    logic [1:0]  req_valid;
    logic [63:0] req_data;
    logic [1:0]  req_ready;

    modport master (
        output req_valid,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_data,
        output req_ready
    );

endinterface

// File: rtl/trig_prm_scheduler_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter, purely combinational. The last-grant pointer is
// held by the caller so it only moves on an actual accept.
//   valid    [1:0] requests
//   advance        grant allowed this cycle
//   last_ptr       0: req0 was granted last, 1: req1 was granted last
//   grant    [1:0] one-hot grant (all zero when advance=0 or no request)
// -----------------------------------------------------------------------------
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       advance,
    input  logic       last_ptr,
    output logic [1:0] grant
);

    // Pick a lone requester outright; on contention favour the one not granted last.
    always_comb begin
        grant = 2'b00;
        if (advance) begin
            case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_ptr ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end else begin
            grant = 2'b00;
        end
    end

endmodule

// File: rtl/trig_prm_scheduler.sv
// -----------------------------------------------------------------------------
// trig_prm_scheduler
// Accepts parameter-write requests from two sources, waits for a frame-head
// edge of the trigger generator (or a timeout), then issues a single-cycle
// parameter write followed by a settle gap.
// Parameters:
//   P_TIMEOUT  max WAIT_SYNC cycles before a forced write
//   P_SETTLE   idle cycles after each write before the next grant
// Ports:
//   i_clk, i_rst     clock, asynchronous active-high reset
//   req_if           request handshake (slave side)
//   i_head_flag      frame-head flag from the trigger generator
//   i_ena_req        requested generator enable
//   o_ena            generator enable, only updated in IDLE
//   o_prm_we         one-cycle parameter write strobe
//   o_prmeter        parameter word, holds the last written value
//   o_busy           high outside IDLE
//   o_timeout        sticky: the last write was forced by timeout
// -----------------------------------------------------------------------------
module trig_prm_scheduler
    import trig_prm_pkg::*;
#(
    parameter logic [23:0] P_TIMEOUT = TIMEOUT_DEFAULT,
    parameter logic [3:0]  P_SETTLE  = SETTLE_DEFAULT
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    trig_prm_scheduler_if.slave  req_if,
    input  logic                 i_head_flag,
    input  logic                 i_ena_req,
    output logic                 o_ena,
    output logic                 o_prm_we,
    output logic [31:0]          o_prmeter,
    output logic                 o_busy,
    output logic                 o_timeout
);

    state_e      state_q,   state_d;
    logic [23:0] cnt_q,     cnt_d;
    logic [31:0] data_q,    data_d;
    logic        last_q,    last_d;
    logic        head_q,    head_d;
    logic        ena_q,     ena_d;
    logic        prm_we_q,  prm_we_d;
    logic [31:0] prmeter_q, prmeter_d;
    logic        busy_q,    busy_d;
    logic        timeout_q, timeout_d;

    logic [1:0]  grant_s;
    logic [31:0] sel_word_s;
    logic        head_edge_s;
    logic        settle_done_s;

    rr_arb2 u_arb (
        .valid    (req_if.req_valid),
        .advance  (state_q == ST_IDLE),
        .last_ptr (last_q),
        .grant    (grant_s)
    );

    // Ready is the grant itself so the requester sees the accept in the cycle
    // its word is latched; it is forced low while reset is held.
    assign req_if.req_ready = i_rst ? 2'b00 : grant_s;

    assign sel_word_s    = grant_s[1] ? req_if.req_data[63:32] : req_if.req_data[31:0];
    assign head_edge_s   = i_head_flag & ~head_q;
    // cnt_q counts settle cycles already spent, so this is the last one.
    assign settle_done_s = (cnt_q + 24'd1) >= {20'd0, P_SETTLE};

    // Next-state and datapath updates.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        last_d    = last_q;
        ena_d     = ena_q;
        timeout_d = timeout_q;
        head_d    = i_head_flag;

        case (state_q)
            ST_IDLE: begin
                ena_d = i_ena_req;
                cnt_d = 24'd0;
                if (grant_s != 2'b00) begin
                    data_d    = sel_word_s;
                    last_d    = grant_s[1];
                    timeout_d = 1'b0;
                    state_d   = ST_WAIT_SYNC;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_WAIT_SYNC: begin
                // A head edge is checked first so it wins over a coincident timeout.
                if (!ena_q || head_edge_s) begin
                    state_d = ST_WRITE;
                end else if (cnt_q == P_TIMEOUT) begin
                    timeout_d = 1'b1;
                    state_d   = ST_WRITE;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            ST_WRITE: begin
                cnt_d   = 24'd0;
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_done_s) begin
                    cnt_d   = 24'd0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = cnt_q + 24'd1;
                end
            end
            default: begin
                cnt_d   = 24'd0;
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        prm_we_d  = (state_d == ST_WRITE);
        prmeter_d = (state_d == ST_WRITE) ? data_d : prmeter_q;
        busy_d    = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 24'd0;
            data_q    <= 32'd0;
            last_q    <= 1'b1;
            head_q    <= 1'b0;
            ena_q     <= 1'b0;
            prm_we_q  <= 1'b0;
            prmeter_q <= 32'd0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            last_q    <= last_d;
            head_q    <= head_d;
            ena_q     <= ena_d;
            prm_we_q  <= prm_we_d;
            prmeter_q <= prmeter_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_ena     = ena_q;
    assign o_prm_we  = prm_we_q;
    assign o_prmeter = prmeter_q;
    assign o_busy    = busy_q;
    assign o_timeout = timeout_q;

endmodule

// File: tb/tb_trig_prm_scheduler.sv
// -----------------------------------------------------------------------------
// tb_trig_prm_scheduler
// Directed self-checking bench for trig_prm_scheduler with P_TIMEOUT=100 and
// P_SETTLE=4. Inputs change just after the falling edge, outputs are sampled
// 1 time unit later, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_trig_prm_scheduler;
    import trig_prm_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        head;
    logic        ena_req;
    logic        ena;
    logic        we;
    logic [31:0] prm;
    logic        busy;
    logic        tmo;

    int total = 0;
    int bad   = 0;

    trig_prm_scheduler_if rif();

    trig_prm_scheduler #(
        .P_TIMEOUT (24'd100),
        .P_SETTLE  (4'd4)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .req_if      (rif),
        .i_head_flag (head),
        .i_ena_req   (ena_req),
        .o_ena       (ena),
        .o_prm_we    (we),
        .o_prmeter   (prm),
        .o_busy      (busy),
        .o_timeout   (tmo)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        rif.req_valid = 2'b00;
        repeat (2) step();
        rst = 1'b0;
        #1;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            step();
            #1;
            n++;
        end
        check_val(tag, busy, 1'b0);
    endtask

    // Main stimulus.
    initial begin
        logic [1:0]  gr   [3];
        int          gcyc [3];
        logic [31:0] wd   [3];
        int          ngr;
        int          nw;
        int          early;

        rst           = 1'b1;
        head          = 1'b0;
        ena_req       = 1'b0;
        rif.req_valid = 2'b00;
        rif.req_data  = 64'd0;
        repeat (3) step();
        rst = 1'b0;
        #1;

        // Reset state
        check_val("rst_ena",   ena, 1'b0);
        check_val("rst_busy",  busy, 1'b0);
        check_val("rst_we",    we, 1'b0);
        check_val("rst_prm",   prm, 32'd0);
        check_val("rst_tmo",   tmo, 1'b0);
        check_val("rst_ready", rif.req_ready, 2'b00);

        // Minimum latency with enable off: ready at T, write at T+2
        step(); rif.req_valid = 2'b01; rif.req_data = {32'd0, 32'h0300_0400}; #1;
        check_val("lat_ready_T", rif.req_ready, 2'b01);
        check_val("lat_busy_T",  busy, 1'b0);
        step(); rif.req_valid = 2'b00; #1;
        check_val("lat_ready_T1", rif.req_ready, 2'b00);
        check_val("lat_busy_T1",  busy, 1'b1);
        check_val("lat_we_T1",    we, 1'b0);
        step(); #1;
        check_val("lat_we_T2",  we, 1'b1);
        check_val("lat_prm_T2", prm, 32'h0300_0400);
        check_val("lat_tmo_T2", tmo, 1'b0);
        step(); #1;
        check_val("lat_we_T3",   we, 1'b0);
        check_val("lat_prm_hold", prm, 32'h0300_0400);
        repeat (3) step(); #1;
        check_val("settle_busy_T6", busy, 1'b1);
        step(); #1;
        check_val("settle_idle_T7", busy, 1'b0);

        // Round robin from reset with both requesters held
        do_reset();
        step(); rif.req_valid = 2'b11; rif.req_data = {32'h0200_0011, 32'h0200_0022}; #1;
        ngr = 0; nw = 0;
        for (int i = 0; i < 3; i++) begin gr[i] = 2'b00; gcyc[i] = 0; wd[i] = 32'd0; end
        for (int n = 0; n < 80 && nw < 3; n++) begin
            if (rif.req_ready != 2'b00 && ngr < 3) begin
                gr[ngr] = rif.req_ready; gcyc[ngr] = n; ngr++;
            end
            if (we && nw < 3) begin
                wd[nw] = prm; nw++;
            end
            step();
            if (ngr >= 3) rif.req_valid = 2'b00;
            #1;
        end
        check_val("rr_ngrants", ngr, 3);
        check_val("rr_nwrites", nw, 3);
        check_val("rr_g0", gr[0], 2'b01);
        check_val("rr_g1", gr[1], 2'b10);
        check_val("rr_g2", gr[2], 2'b01);
        check_val("rr_w0", wd[0], 32'h0200_0022);
        check_val("rr_w1", wd[1], 32'h0200_0011);
        check_val("rr_w2", wd[2], 32'h0200_0022);
        check_val("rr_gap1", (gcyc[1] - gcyc[0]) >= 7, 1'b1);
        check_val("rr_gap2", (gcyc[2] - gcyc[1]) >= 7, 1'b1);
        wait_idle("rr_idle", 20);

        // Enable on, head edge 50 cycles after accept
        step(); ena_req = 1'b1; #1;
        step(); #1;
        check_val("sync_ena_on", ena, 1'b1);
        step(); rif.req_valid = 2'b01; rif.req_data = {32'd0, prm_word(1'b1, 1'b0, 24'h000010)}; #1;
        check_val("sync_ready", rif.req_ready, 2'b01);
        early = 0;
        for (int k = 1; k <= 49; k++) begin
            step(); rif.req_valid = 2'b00; #1;
            if (we) early++;
        end
        step(); head = 1'b1; #1;
        if (we) early++;
        check_val("sync_no_early_we", early, 0);
        step(); #1;
        check_val("sync_we",  we, 1'b1);
        check_val("sync_prm", prm, 32'h0200_0010);
        check_val("sync_tmo", tmo, 1'b0);
        step(); head = 1'b0; #1;
        wait_idle("sync_idle", 20);

        // Timeout with no head edge: write at accept+102
        step(); rif.req_valid = 2'b01; rif.req_data = {32'd0, 32'h0100_0100}; #1;
        check_val("tmo_ready", rif.req_ready, 2'b01);
        early = 0;
        step(); rif.req_valid = 2'b00; #1;
        check_val("tmo_flag_low_wait", tmo, 1'b0);
        for (int k = 2; k <= 101; k++) begin
            step(); #1;
            if (we) early++;
        end
        check_val("tmo_no_early_we", early, 0);
        step(); #1;
        check_val("tmo_we",   we, 1'b1);
        check_val("tmo_flag", tmo, 1'b1);
        check_val("tmo_prm",  prm, 32'h0100_0100);
        wait_idle("tmo_idle", 20);
        check_val("tmo_sticky", tmo, 1'b1);

        // Coincident head edge and timeout: edge wins
        step(); rif.req_valid = 2'b01; rif.req_data = {32'd0, 32'h0000_0055}; #1;
        check_val("coin_ready", rif.req_ready, 2'b01);
        check_val("coin_tmo_before_clear", tmo, 1'b1);
        step(); rif.req_valid = 2'b00; #1;
        check_val("coin_tmo_cleared", tmo, 1'b0);
        early = 0;
        for (int k = 2; k <= 100; k++) begin
            step(); #1;
            if (we) early++;
        end
        step(); head = 1'b1; #1;
        if (we) early++;
        check_val("coin_no_early_we", early, 0);
        step(); #1;
        check_val("coin_we",  we, 1'b1);
        check_val("coin_tmo", tmo, 1'b0);
        check_val("coin_prm", prm, 32'h0000_0055);
        step(); head = 1'b0; #1;
        wait_idle("coin_idle", 20);

        // Enable change while busy takes effect on the first IDLE cycle
        step(); rif.req_valid = 2'b01; rif.req_data = {32'd0, 32'h0300_0777}; #1;
        check_val("ena_ready", rif.req_ready, 2'b01);
        step(); rif.req_valid = 2'b00; ena_req = 1'b0; #1;
        for (int k = 2; k <= 9; k++) begin
            step(); #1;
        end
        check_val("ena_hold_wait", ena, 1'b1);
        step(); head = 1'b1; #1;
        step(); #1;
        check_val("ena_we",   we, 1'b1);
        check_val("ena_hold_write", ena, 1'b1);
        step(); head = 1'b0; #1;
        repeat (3) step(); #1;
        check_val("ena_busy_settle", busy, 1'b1);
        step(); #1;
        check_val("ena_first_idle_busy", busy, 1'b0);
        check_val("ena_first_idle_ena",  ena, 1'b1);
        step(); #1;
        check_val("ena_updated", ena, 1'b0);

        // Enable change and request in the same IDLE cycle
        step(); ena_req = 1'b1; rif.req_valid = 2'b01; rif.req_data = {32'd0, 32'h0200_0123}; #1;
        check_val("same_ready", rif.req_ready, 2'b01);
        check_val("same_ena_before", ena, 1'b0);
        step(); rif.req_valid = 2'b00; #1;
        check_val("same_ena_after", ena, 1'b1);
        check_val("same_busy", busy, 1'b1);

        // Reset pulsed during WAIT_SYNC
        step(); step(); rif.req_valid = 2'b01; rst = 1'b1; #1;
        check_val("mid_rst_ena",   ena, 1'b0);
        check_val("mid_rst_busy",  busy, 1'b0);
        check_val("mid_rst_we",    we, 1'b0);
        check_val("mid_rst_prm",   prm, 32'd0);
        check_val("mid_rst_tmo",   tmo, 1'b0);
        check_val("mid_rst_ready", rif.req_ready, 2'b00);
        step(); step(); rif.req_valid = 2'b00; rst = 1'b0; #1;
        early = 0;
        for (int k = 0; k < 30; k++) begin
            step(); head = (k == 5); #1;
            if (we) early++;
        end
        check_val("mid_rst_no_we", early, 0);
        check_val("mid_rst_prm_after", prm, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
